// File: rtl/solver_loader_if.sv
// Host stream, solver write/start port and result port of solver_loader,
// bundled so the loader and its host/solver side connect through one port.
interface solver_loader_if #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int ITER_BITS       = 16
);

  // host job stream
  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs;
  logic [ITER_BITS-1:0]       cfg_iter_lim;
  logic                       in_valid;
  logic                       in_ready;
  logic [LIMB_SIZE_BITS-1:0]  in_re;
  logic [LIMB_SIZE_BITS-1:0]  in_im;

  // solver load port
  logic                       wr_real_en;
  logic                       wr_imag_en;
  logic [LIMB_INDEX_BITS-1:0] wr_index;
  logic [LIMB_SIZE_BITS-1:0]  real_data;
  logic [LIMB_SIZE_BITS-1:0]  imag_data;
  logic                       wr_num_limbs_en;
  logic                       wr_iter_lim_en;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
  logic [ITER_BITS-1:0]       iter_lim_data;

  // solver control and completion
  logic                       start;
  logic                       out_ready;
  logic [ITER_BITS-1:0]       iterations;

  // result port and status
  logic                       res_valid;
  logic                       res_ready;
  logic [ITER_BITS-1:0]       res_iterations;
  logic                       busy;

  // the loader's own view
  modport slave (
    input  cfg_num_limbs, cfg_iter_lim, in_valid, in_re, in_im,
    input  out_ready, iterations, res_ready,
    output in_ready,
    output wr_real_en, wr_imag_en, wr_index, real_data, imag_data,
    output wr_num_limbs_en, wr_iter_lim_en, num_limbs_data, iter_lim_data,
    output start, res_valid, res_iterations, busy
  );

  // the host/solver side that drives the loader
  modport master (
    output cfg_num_limbs, cfg_iter_lim, in_valid, in_re, in_im,
    output out_ready, iterations, res_ready,
    input  in_ready,
    input  wr_real_en, wr_imag_en, wr_index, real_data, imag_data,
    input  wr_num_limbs_en, wr_iter_lim_en, num_limbs_data, iter_lim_data,
    input  start, res_valid, res_iterations, busy
  );

endinterface

// File: rtl/solver_loader.sv
// solver_loader: takes one job (limb pairs plus limb count and iteration
// limit) from a host stream, writes it into the solver, starts the solver,
// waits for a fresh rising edge of its done flag and hands the iteration
// count back on a valid/ready result port. All outputs are registered.
module solver_loader #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int ITER_BITS       = 16
) (
  input logic          clock,
  input logic          reset,
  solver_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    RESULT
  } state_t;

  state_t                     state;
  logic [LIMB_INDEX_BITS-1:0] num_limbs;
  logic [LIMB_INDEX_BITS-1:0] idx;
  logic                       prev;
  logic                       accept;
  logic                       done;

  // a limb is taken whenever the host offers one while we advertise ready
  assign accept = bus.in_valid & bus.in_ready;

  // only a fresh rising edge of the solver's done flag completes a job, so a
  // level left high by the previous job cannot end this one early
  assign done = bus.out_ready & ~prev;

  // single job sequencer: load limbs, launch, wait for done, return result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      num_limbs          <= '0;
      idx                <= '0;
      prev               <= 1'b1;
      bus.in_ready       <= 1'b0;
      bus.wr_real_en     <= 1'b0;
      bus.wr_imag_en     <= 1'b0;
      bus.wr_index       <= '0;
      bus.real_data      <= '0;
      bus.imag_data      <= '0;
      bus.wr_num_limbs_en <= 1'b0;
      bus.wr_iter_lim_en <= 1'b0;
      bus.num_limbs_data <= '0;
      bus.iter_lim_data  <= '0;
      bus.start          <= 1'b0;
      bus.res_valid      <= 1'b0;
      bus.res_iterations <= '0;
      bus.busy           <= 1'b0;
    end else begin
      // write strobes are single-cycle pulses unless re-armed below
      bus.wr_real_en      <= 1'b0;
      bus.wr_imag_en      <= 1'b0;
      bus.wr_num_limbs_en <= 1'b0;
      bus.wr_iter_lim_en  <= 1'b0;

      case (state)
        IDLE: begin
          // a zero limb count is not a job, so do not offer to take one
          bus.in_ready <= (bus.cfg_num_limbs != '0);
          if (accept) begin
            num_limbs           <= bus.cfg_num_limbs;
            bus.wr_real_en      <= 1'b1;
            bus.wr_imag_en      <= 1'b1;
            bus.wr_index        <= '0;
            bus.real_data       <= bus.in_re;
            bus.imag_data       <= bus.in_im;
            bus.wr_num_limbs_en <= 1'b1;
            bus.wr_iter_lim_en  <= 1'b1;
            bus.num_limbs_data  <= bus.cfg_num_limbs;
            bus.iter_lim_data   <= bus.cfg_iter_lim;
            bus.busy            <= 1'b1;
            // a count that dropped to zero on the accept cycle is handled
            // like a single limb so the index can never run away
            if (bus.cfg_num_limbs <= LIMB_INDEX_BITS'(1)) begin
              state        <= START;
              bus.in_ready <= 1'b0;
            end else begin
              state        <= LOAD;
              idx          <= LIMB_INDEX_BITS'(1);
              bus.in_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            bus.wr_real_en <= 1'b1;
            bus.wr_imag_en <= 1'b1;
            bus.wr_index   <= idx;
            bus.real_data  <= bus.in_re;
            bus.imag_data  <= bus.in_im;
            if (idx == num_limbs - LIMB_INDEX_BITS'(1)) begin
              state        <= START;
              bus.in_ready <= 1'b0;
            end else begin
              idx <= idx + LIMB_INDEX_BITS'(1);
            end
          end
        end

        START: begin
          // gap cycle after the last write; arm the edge detector so the
          // first RUN cycle never sees a rising edge
          state <= RUN;
          prev  <= 1'b1;
        end

        RUN: begin
          bus.start <= 1'b1;
          prev      <= bus.out_ready;
          if (done) begin
            bus.res_iterations <= bus.iterations;
            bus.start          <= 1'b0;
            bus.res_valid      <= 1'b1;
            state              <= RESULT;
          end
        end

        RESULT: begin
          // ready for the next job on the very edge the result is taken
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= (bus.cfg_num_limbs != '0);
            state         <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.start    <= 1'b0;
          bus.res_valid <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_loader.sv
// Self-checking bench for solver_loader: directed job scenarios plus random
// jobs, compared against a list-of-writes model and a simple solver model.
module tb_solver_loader;

  localparam int LIB = 6;
  localparam int LSB = 8;
  localparam int IB  = 16;

  typedef struct {
    int idx;
    int re;
    int im;
    int cfg;
    int num;
    int iter;
    int cyc;
  } wr_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  job_re[$];
  int  job_im[$];

  solver_loader_if #(.LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB), .ITER_BITS(IB)) bus ();

  solver_loader #(
    .LIMB_INDEX_BITS(LIB),
    .LIMB_SIZE_BITS(LSB),
    .ITER_BITS(IB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // record every solver write as it is presented
  always @(negedge clock) begin
    if (reset === 1'b1 && (bus.wr_real_en || bus.wr_imag_en ||
                           bus.wr_num_limbs_en || bus.wr_iter_lim_en)) begin
      wr_t w;
      check("strobe_pair", 32'(bus.wr_imag_en), 32'(bus.wr_real_en));
      check("cfg_strobe_pair", 32'(bus.wr_iter_lim_en), 32'(bus.wr_num_limbs_en));
      w.idx  = int'(bus.wr_index);
      w.re   = int'(bus.real_data);
      w.im   = int'(bus.imag_data);
      w.cfg  = bus.wr_num_limbs_en ? 1 : 0;
      w.num  = int'(bus.num_limbs_data);
      w.iter = int'(bus.iter_lim_data);
      w.cyc  = cyc;
      obs_q.push_back(w);
    end
  end

  task automatic send_limb(input int re, input int im);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_re    = re[7:0];
    bus.in_im    = im[7:0];
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 32'(bus.in_ready), 1);
    @(negedge clock);
  endtask

  // drive one job; the model is simply the ordered list of writes it implies
  task automatic send_job(input int n, input int lim, input bit gaps,
                          input bit fixed, input int change_at);
    int  re;
    int  im;
    wr_t w;
    exp_q.delete();
    obs_q.delete();
    bus.cfg_num_limbs = n[5:0];
    bus.cfg_iter_lim  = lim[15:0];
    @(negedge clock);
    for (int i = 0; i < n; i++) begin
      re = fixed ? job_re[i] : int'($urandom_range(255));
      im = fixed ? job_im[i] : int'($urandom_range(255));
      w.idx  = i;
      w.re   = re;
      w.im   = im;
      w.cfg  = (i == 0) ? 1 : 0;
      w.num  = n;
      w.iter = lim;
      w.cyc  = 0;
      exp_q.push_back(w);
      send_limb(re, im);
      if (i == change_at) begin
        bus.cfg_num_limbs = 6'd5;
        bus.cfg_iter_lim  = 16'(lim + 1);
      end
      if (gaps) begin
        bus.in_valid = 1'b0;
        @(negedge clock);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(output int start_cyc);
    int guard = 0;
    while (bus.start !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check("start_seen", 32'(bus.start), 1);
    start_cyc = cyc;
  endtask

  // compare the writes, then play the solver and take the result
  task automatic finish_job(input int iters, input int res_wait,
                            input bit stale, input bit gaps);
    int start_cyc;
    int last;
    wait_start(start_cyc);
    check("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("wr_index", obs_q[i].idx, exp_q[i].idx);
      check("real_data", obs_q[i].re, exp_q[i].re);
      check("imag_data", obs_q[i].im, exp_q[i].im);
      check("cfg_strobe", obs_q[i].cfg, exp_q[i].cfg);
      if (i == 0) begin
        check("num_limbs_data", obs_q[i].num, exp_q[i].num);
        check("iter_lim_data", obs_q[i].iter, exp_q[i].iter);
      end
    end
    if (obs_q.size() > 0) begin
      last = obs_q.size() - 1;
      check("start_delay", start_cyc - obs_q[last].cyc, 2);
      if (!gaps) check("back_to_back", obs_q[last].cyc - obs_q[0].cyc, exp_q.size() - 1);
    end
    check("busy_run", 32'(bus.busy), 1);
    check("in_ready_run", 32'(bus.in_ready), 0);

    if (stale) begin
      repeat (2) begin
        @(negedge clock);
        check("stale_high", 32'(bus.res_valid), 0);
      end
      bus.out_ready = 1'b0;
      repeat (3) begin
        @(negedge clock);
        check("stale_low", 32'(bus.res_valid), 0);
      end
    end else begin
      repeat ($urandom_range(3)) begin
        @(negedge clock);
        check("run_wait", 32'(bus.res_valid), 0);
      end
    end
    bus.iterations = iters[15:0];
    bus.out_ready  = 1'b1;
    @(negedge clock);
    check("res_valid", 32'(bus.res_valid), 1);
    check("start_drop", 32'(bus.start), 0);
    check("res_iterations", 32'(bus.res_iterations), iters);
    bus.out_ready = 1'b0;
    repeat (res_wait) begin
      @(negedge clock);
      check("res_hold_valid", 32'(bus.res_valid), 1);
      check("res_hold_value", 32'(bus.res_iterations), iters);
      check("res_hold_in_ready", 32'(bus.in_ready), 0);
      check("res_hold_busy", 32'(bus.busy), 1);
    end
    bus.res_ready = 1'b1;
    @(negedge clock);
    bus.res_ready = 1'b0;
    check("res_taken", 32'(bus.res_valid), 0);
    check("busy_idle", 32'(bus.busy), 0);
    check("in_ready_idle", 32'(bus.in_ready), (bus.cfg_num_limbs != 0) ? 1 : 0);
  endtask

  // directed scenarios followed by random jobs
  initial begin
    int start_cyc;
    int n;
    int lim;
    reset              = 1'b0;
    bus.cfg_num_limbs  = '0;
    bus.cfg_iter_lim   = '0;
    bus.in_valid       = 1'b0;
    bus.in_re          = '0;
    bus.in_im          = '0;
    bus.out_ready      = 1'b0;
    bus.iterations     = '0;
    bus.res_ready      = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_start", 32'(bus.start), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_wr_en", 32'(bus.wr_real_en), 0);
    check("rst_res_iter", 32'(bus.res_iterations), 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_zero_cfg", 32'(bus.in_ready), 0);

    $display("[TB] basic job");
    job_re = '{0, 'h80};
    job_im = '{0, 0};
    send_job(2, 10, 1'b0, 1'b1, -1);
    finish_job(10, 0, 1'b0, 1'b0);

    $display("[TB] single limb");
    job_re = '{'h40};
    job_im = '{'hC0};
    send_job(1, 200, 1'b0, 1'b1, -1);
    finish_job(123, 1, 1'b0, 1'b0);

    $display("[TB] back-pressure and gaps");
    send_job(4, 500, 1'b1, 1'b0, -1);
    finish_job(321, 5, 1'b0, 1'b1);

    $display("[TB] stale out_ready");
    bus.out_ready = 1'b1;
    send_job(2, 50, 1'b0, 1'b0, -1);
    finish_job(7, 0, 1'b1, 1'b0);

    $display("[TB] zero count and config change");
    obs_q.delete();
    bus.cfg_num_limbs = '0;
    @(negedge clock);
    check("zero_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clock);
    check("zero_busy", 32'(bus.busy), 0);
    check("zero_writes", obs_q.size(), 0);
    bus.in_valid = 1'b0;
    send_job(3, 77, 1'b0, 1'b0, 0);
    finish_job(40, 0, 1'b0, 1'b0);

    $display("[TB] reset mid-run");
    send_job(3, 90, 1'b0, 1'b0, -1);
    wait_start(start_cyc);
    #2 reset = 1'b0;
    #1;
    check("arst_start", 32'(bus.start), 0);
    check("arst_res_valid", 32'(bus.res_valid), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    send_job(2, 60, 1'b0, 1'b0, -1);
    finish_job(59, 2, 1'b0, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 6; j++) begin
      n   = int'($urandom_range(1, 8));
      lim = int'($urandom_range(1, 1000));
      send_job(n, lim, 1'(j % 2), 1'b0, -1);
      finish_job(int'($urandom_range(lim)), int'($urandom_range(3)), 1'b0, 1'(j % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
